// File: rtl/firebird7_in_gate1_insysbist_secure_mux_ctrl.sv
// Key-qualified IJTAG controller for the in-system BIST secure scan mux select.
// Every select change runs break-before-make, and the downstream scan enable is gated while it runs.
module firebird7_in_gate1_insysbist_secure_mux_ctrl #(
  parameter int                  KEY_WIDTH = 16,
  parameter logic [KEY_WIDTH-1:0] KEY      = 16'hA5C3,
  parameter int                  MAX_FAIL  = 3,
  parameter int                  SETTLE    = 2
) (
  input  logic       ijtag_tck,
  input  logic       ijtag_reset,
  input  logic       ijtag_sel,
  input  logic       ijtag_ce,
  input  logic       ijtag_se,
  input  logic       ijtag_ue,
  input  logic       ijtag_si,
  output logic       ijtag_so,
  input  logic       secure_enable,
  input  logic       en_in,
  output logic       en_out,
  output logic       mux_select,
  output logic       lockout,
  output logic [2:0] fail_count
);

  localparam int N  = KEY_WIDTH + 1;
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BREAK = 2'd1,
    MAKE  = 2'd2
  } state_t;

  state_t          state;
  logic [N-1:0]    sr;
  logic [CW-1:0]   settle_cnt;
  logic            target;

  logic do_cap, do_shift, do_upd;
  logic req_sel, key_ok, in_idle;
  logic force_close, upd_take, upd_accept, upd_reject;
  logic settle_done;

  always_comb begin
    do_cap      = ijtag_sel & ijtag_ce;
    do_shift    = ijtag_sel & ~ijtag_ce & ijtag_se;
    do_upd      = ijtag_sel & ~ijtag_ce & ~ijtag_se & ijtag_ue;
    req_sel     = sr[0];
    key_ok      = (sr[N-1:1] == KEY) & secure_enable;
    in_idle     = (state == IDLE);
    // Forced close outranks any update arriving in the same cycle.
    force_close = in_idle & mux_select & ~secure_enable;
    upd_take    = in_idle & do_upd & ~lockout & ~force_close;
    upd_accept  = upd_take & (~req_sel | key_ok);
    upd_reject  = upd_take & req_sel & ~key_ok;
    settle_done = (settle_cnt == CW'(SETTLE - 1));
  end

  assign ijtag_so = sr[0];
  assign en_out   = en_in & in_idle & ~ijtag_reset;

  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state      <= IDLE;
      sr         <= '0;
      settle_cnt <= '0;
      target     <= 1'b0;
      mux_select <= 1'b0;
      lockout    <= 1'b0;
      fail_count <= '0;
    end else begin
      if (do_cap)
        sr <= {{(N-5){1'b0}}, fail_count, lockout, mux_select};
      else if (do_shift)
        sr <= {ijtag_si, sr[N-1:1]};

      if (upd_accept && req_sel)
        fail_count <= '0;
      // A reject is only taken while unlocked, so fail_count is below MAX_FAIL here.
      if (upd_reject) begin
        fail_count <= fail_count + 3'd1;
        if (fail_count == 3'(MAX_FAIL - 1))
          lockout <= 1'b1;
      end

      case (state)
        IDLE: begin
          settle_cnt <= '0;
          if (force_close) begin
            target <= 1'b0;
            state  <= BREAK;
          end else if (upd_accept && (req_sel != mux_select)) begin
            target <= req_sel;
            state  <= BREAK;
          end
        end
        BREAK: begin
          if (settle_done) begin
            mux_select <= target;
            settle_cnt <= '0;
            state      <= MAKE;
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end
        MAKE: begin
          if (settle_done) begin
            settle_cnt <= '0;
            state      <= IDLE;
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end
        default: begin
          settle_cnt <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_firebird7_in_gate1_insysbist_secure_mux_ctrl.sv
// Bench for the secure mux controller: directed scenarios plus random traffic,
// all checked every cycle against a cycle-count reference model.
module tb_firebird7_in_gate1_insysbist_secure_mux_ctrl;

  localparam int          KW       = 16;
  localparam logic [15:0] KEY      = 16'hA5C3;
  localparam int          MAX_FAIL = 3;
  localparam int          SETTLE   = 2;
  localparam int          N        = KW + 1;

  logic tck = 1'b0;
  logic rst, sel, ce, se, ue, si, sec, en_in;
  logic so, en_out, mux, lock;
  logic [2:0] fc;

  firebird7_in_gate1_insysbist_secure_mux_ctrl #(
    .KEY_WIDTH(KW), .KEY(KEY), .MAX_FAIL(MAX_FAIL), .SETTLE(SETTLE)
  ) dut (
    .ijtag_tck(tck), .ijtag_reset(rst), .ijtag_sel(sel), .ijtag_ce(ce),
    .ijtag_se(se), .ijtag_ue(ue), .ijtag_si(si), .ijtag_so(so),
    .secure_enable(sec), .en_in(en_in), .en_out(en_out),
    .mux_select(mux), .lockout(lock), .fail_count(fc)
  );

  always #5 tck = ~tck;

  // Reference state: a sequence is simply "busy cycles remaining".
  logic [N-1:0] m_sr;
  int           m_busy;
  logic         m_tgt, m_mux, m_lock;
  int           m_fc;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic model_edge();
    logic [N-1:0] nsr;
    bit idle, start;
    logic ntgt;
    if (rst) begin
      m_sr = '0; m_busy = 0; m_tgt = 0; m_mux = 0; m_lock = 0; m_fc = 0;
      return;
    end
    nsr = m_sr; idle = (m_busy == 0); start = 0; ntgt = m_tgt;
    if (sel && ce) begin
      nsr = '0;
      nsr[4:0] = {m_fc[2:0], m_lock, m_mux};
    end else if (sel && se) begin
      nsr = {si, m_sr[N-1:1]};
    end
    if (idle && m_mux && !sec) begin
      start = 1; ntgt = 0;
    end else if (idle && sel && !ce && !se && ue && !m_lock) begin
      if (!m_sr[0] || (m_sr[N-1:1] == KEY && sec)) begin
        if (m_sr[0]) m_fc = 0;
        if (m_sr[0] != m_mux) begin start = 1; ntgt = m_sr[0]; end
      end else begin
        if (m_fc < MAX_FAIL) m_fc++;
        if (m_fc == MAX_FAIL) m_lock = 1;
      end
    end
    if (!idle) begin
      m_busy--;
      if (m_busy == SETTLE) m_mux = m_tgt;
    end
    if (start) m_busy = 2 * SETTLE;
    m_tgt = ntgt;
    m_sr  = nsr;
  endtask

  task automatic cyc();
    en_in = 1'($urandom_range(0, 1));
    @(posedge tck);
    model_edge();
    @(negedge tck);
    chk("ijtag_so",   so,     m_sr[0]);
    chk("en_out",     en_out, en_in & (m_busy == 0) & ~rst);
    chk("mux_select", mux,    m_mux);
    chk("lockout",    lock,   m_lock);
    chk("fail_count", fc,     m_fc);
  endtask

  task automatic shift_cmd(input logic [15:0] key, input logic req);
    logic [N-1:0] w;
    w = {key, req};
    sel = 1; ce = 0; ue = 0;
    for (int i = 0; i < N; i++) begin
      se = 1; si = w[i];
      cyc();
    end
    se = 0; si = 0;
  endtask

  task automatic update();
    sel = 1; ue = 1; cyc(); ue = 0;
  endtask

  task automatic capture();
    sel = 1; ce = 1; cyc(); ce = 0;
  endtask

  task automatic do_reset();
    rst = 1; cyc(); cyc(); rst = 0;
  endtask

  initial begin
    logic [4:0] exp_cap;
    rst = 1; sel = 0; ce = 0; se = 0; ue = 0; si = 0; sec = 1; en_in = 0;
    m_sr = '0; m_busy = 0; m_tgt = 0; m_mux = 0; m_lock = 0; m_fc = 0;
    do_reset();

    // Capture after reset and shift the whole register out.
    capture();
    for (int i = 0; i < N; i++) begin
      se = 1; si = 0; cyc();
      chk("rst_so_zero", so, 0);
    end
    se = 0;

    // Correct-key unlock: select flips two edges after the update.
    shift_cmd(KEY, 1'b1);
    update();
    chk("unlock_gap", en_out, 0);
    cyc();
    chk("unlock_mux_e1", mux, 0);
    cyc();
    chk("unlock_mux_e2", mux, 1);
    cyc(); cyc();
    chk("unlock_fc", fc, 0);

    // Forced close beats a same-cycle key-qualified update.
    shift_cmd(KEY, 1'b1);
    sec = 0; ue = 1; cyc(); ue = 0;
    cyc(); cyc();
    chk("fclose_mux", mux, 0);
    cyc(); cyc();
    sec = 1;

    // Update during BREAK is ignored: build mux=1, then force close with a bad key pending.
    shift_cmd(KEY, 1'b1); update(); repeat (4) cyc();
    shift_cmd(16'h0000, 1'b1);
    sec = 0; cyc(); sec = 1;
    update();
    chk("brk_upd_fc", fc, 0);
    repeat (4) cyc();

    // Three bad keys lock the controller.
    for (int k = 1; k <= 3; k++) begin
      shift_cmd(16'h0000, 1'b1);
      update();
      chk("fail_step", fc, k);
    end
    chk("locked", lock, 1);
    shift_cmd(KEY, 1'b1); update(); repeat (4) cyc();
    chk("locked_mux", mux, 0);
    capture();
    exp_cap = 5'b01110;
    for (int i = 0; i < 5; i++) begin
      chk("lock_cap_bit", so, exp_cap[i]);
      se = 1; si = 0; cyc();
    end
    se = 0;

    // Reset during MAKE aborts the sequence.
    do_reset();
    shift_cmd(KEY, 1'b1); update(); cyc(); cyc(); cyc();
    rst = 1; cyc();
    chk("mid_rst_mux", mux, 0);
    rst = 0; cyc();
    chk("post_rst_en", en_out, en_in);

    // Random traffic.
    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        shift_cmd(($urandom_range(0, 1) != 0) ? KEY : 16'($urandom), 1'($urandom_range(0, 1)));
        sel = ($urandom_range(0, 7) != 0);
        ue = 1; cyc(); ue = 0; sel = 1;
      end else if (r == 4) begin
        capture();
        for (int i = 0; i < int'($urandom_range(1, N)); i++) begin
          se = 1; si = 1'($urandom_range(0, 1)); cyc();
        end
        se = 0;
      end else if (r == 5) begin
        sec = ~sec; cyc();
      end else if (r == 6) begin
        sel = 1'($urandom_range(0, 1)); ce = 1'($urandom_range(0, 1));
        se = 1'($urandom_range(0, 1)); ue = 1'($urandom_range(0, 1));
        si = 1'($urandom_range(0, 1));
        cyc();
        sel = 1; ce = 0; se = 0; ue = 0;
      end else if (r == 7 && $urandom_range(0, 2) == 0) begin
        rst = 1; cyc(); rst = 0;
      end else begin
        repeat ($urandom_range(1, 5)) cyc();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/firebird7_in_gate1_insysbist_secure_mux_ctrl.md
# firebird7_in_gate1_insysbist_secure_mux_ctrl

IJTAG-accessible controller for the in-system BIST secure scan mux. It owns the mux select register and opens the insysbist path (select=1) only after a key-qualified update while `secure_enable` is high. Every select change runs a break-before-make sequence that gates the downstream scan enable. It sits in the gate1 IJTAG network between the parent segment's shift/update controls and the secure mux's `mux_select`/`enable_in` pins.

## Interface
Parameters:
- `KEY_WIDTH`, 16: key field width; legal range ≥ 8.
- `KEY`, 16'hA5C3: unlock key.
- `MAX_FAIL`, 3: failed unlock attempts before lockout; legal range 1..7.
- `SETTLE`, 2: cycles per break/make phase; legal range ≥ 1.

Ports (clock and reset first):
- `ijtag_tck`  in  1  the single clock; all state changes on its rising edge.
- `ijtag_reset`  in  1  synchronous, active-high reset.
- `ijtag_sel`  in  1  segment select.
- `ijtag_ce`  in  1  capture enable.
- `ijtag_se`  in  1  shift enable.
- `ijtag_ue`  in  1  update enable.
- `ijtag_si`  in  1  scan in.
- `ijtag_so`  out  1  scan out, = `sr[0]` (combinational).
- `secure_enable`  in  1  security qualifier from fuse/lifecycle logic.
- `en_in`  in  1  upstream scan enable.
- `en_out`  out  1  to mux `enable_in`; = `en_in` & (state==IDLE) & ~`ijtag_reset`.
- `mux_select`  out  1  to mux `mux_select`; registered.
- `lockout`  out  1  sticky lockout flag.
- `fail_count`  out  3  failed-attempt counter.

## Operation
- Shift register `sr`: N = KEY_WIDTH+1 bits. Command format: `sr[0]` = req_sel, `sr[N-1:1]` = key.
- Op priority per cycle, with `ijtag_sel`=1: capture > shift > update. With `ijtag_sel`=0: `sr` holds and no update is taken.
- Capture: `sr` ← {zeros, `fail_count`[2:0], `lockout`, `mux_select`}, LSB first.
- Shift: `sr` ← {`ijtag_si`, `sr[N-1:1]`}.
- Update is evaluated only in IDLE; in BREAK or MAKE it is ignored with no counter effect.
  - If `lockout`=1, ignore the update.
  - req_sel=0: always accepted, no key check.
  - req_sel=1 with key==KEY and `secure_enable`=1: accepted, and `fail_count` clears to 0.
  - req_sel=1 otherwise: rejected. `fail_count` increments, saturating at MAX_FAIL. On reaching MAX_FAIL, `lockout`←1, held until reset.
- An accepted update with req_sel≠`mux_select` enters BREAK. An accepted update with req_sel==`mux_select` changes nothing beyond the `fail_count` clear.
- Forced close: `secure_enable`=0 while `mux_select`=1 in IDLE enters BREAK with target 0. This takes priority over a same-cycle update, which is dropped.
- FSM:
  - IDLE → BREAK on an accepted change or forced close.
  - BREAK: SETTLE cycles; `mux_select`←target on exit; → MAKE.
  - MAKE: SETTLE cycles → IDLE.
  - A single settle counter (width clog2(SETTLE+1)) serves both phases.
- `secure_enable` falling during BREAK/MAKE toward target 1: finish the sequence, then forced close runs from IDLE.
- Reset values: state IDLE, `sr`=0, `mux_select`=0, `lockout`=0, `fail_count`=0, `en_out`=0 while reset is asserted.
- Reset asserted mid-sequence aborts it immediately to the reset values.

## Timing
- Update sampled on edge E0 (accepted change):
  - BREAK for the cycles after E0 through E0+SETTLE; `en_out`=0 throughout.
  - `mux_select` toggles on edge E0+SETTLE.
  - MAKE until edge E0+2·SETTLE; `en_out` re-follows `en_in` after it.
  - Total enable gap: 2·SETTLE cycles.
- `fail_count`/`lockout` update on the same edge as the rejected update.
- Capture reflects values registered before the capture edge.
- `ijtag_so` is valid in the same cycle as `sr`; no pipelining.

## Test plan
- Reset, then capture and shift out 17 bits → `ijtag_so` sequence all 0, `en_out`=`en_in`, `mux_select`=0.
- Shift {16'hA5C3, 1}, `secure_enable`=1, update at E0 → `en_out`=0 for 4 cycles, `mux_select`=1 at E0+2, `fail_count`=0.
- Three updates with {16'h0000, 1} → `fail_count` 1, 2, 3; `lockout`=1 on the third. A subsequent correct-key update is ignored, `mux_select` stays 0, and capture shows bits[4:0]=5'b01110.
- `mux_select`=1, drop `secure_enable` in IDLE while a same-cycle update {KEY, 1} is issued → update dropped, break-before-make runs, `mux_select`=0 after 2 cycles, `en_out` restored after 4.
- Update during BREAK → ignored, sequence timing unchanged, `fail_count` unchanged.
- Assert `ijtag_reset` during MAKE → next cycle state IDLE, `mux_select`=0, `en_out`=`en_in` once reset is released.
